// File: rtl/calc_retime_pkg.sv
// Shared types and constants for the calculator output retiming stage.
// Default widths, response codes, lane entry layout and index-width helpers.
package calc_retime_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RESP_W_DEF = 2;

  localparam int RESP_NONE = 0;
  localparam int RESP_OK   = 1;
  localparam int RESP_OVF  = 2;
  localparam int RESP_ERR  = 3;

  typedef struct packed {
    logic [RESP_W_DEF-1:0] resp;
    logic [DATA_W_DEF-1:0] data;
  } lane_entry_t;

  // Width of a delay value able to hold 0..max_dly.
  function automatic int dly_w(input int max_dly);
    return (max_dly >= 1) ? $clog2(max_dly + 1) : 1;
  endfunction

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_retime_lane.sv
// One port's retiming lane: MAX_DLY-stage shifter, delay register and tap mux; latency = dly cycles (0 = bypass).
// No backpressure: the shifter advances every cycle; empty reports no response held or arriving.
module calc_retime_lane
  import calc_retime_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RESP_W  = RESP_W_DEF,
  parameter int MAX_DLY = 4,
  parameter int DLY_RST = 0
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [RESP_W-1:0]         in_resp,
  input  logic                      dly_ld,
  input  logic [dly_w(MAX_DLY)-1:0] dly_val,
  output logic                      empty,
  output logic [DATA_W-1:0]         out_data,
  output logic [RESP_W-1:0]         out_resp
);

  localparam int DW = dly_w(MAX_DLY);

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          gated;
  entry_t          tap;
  entry_t          stage [MAX_DLY];
  logic [DW-1:0]   dly;
  logic            busy;

  // Data is forced to zero whenever there is no response to carry.
  always_comb begin
    gated.resp = in_resp;
    gated.data = (in_resp != RESP_W'(RESP_NONE)) ? in_data : '0;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_DLY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= gated;
      for (int i = 1; i < MAX_DLY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      dly <= DW'(DLY_RST);
    end else if (dly_ld) begin
      dly <= dly_val;
    end
  end

  always_comb begin
    tap = gated;
    for (int i = 0; i < MAX_DLY; i++) begin
      if (int'(dly) == i + 1) begin
        tap = stage[i];
      end
    end
  end

  // Every stage counts, including those past the current tap, so a shorter delay never exposes old entries.
  always_comb begin
    busy = (in_resp != RESP_W'(RESP_NONE));
    for (int i = 0; i < MAX_DLY; i++) begin
      busy = busy | (stage[i].resp != RESP_W'(RESP_NONE));
    end
  end

  assign empty    = !busy;
  assign out_data = tap.data;
  assign out_resp = tap.resp;

endmodule

// File: rtl/calc_out_retimer.sv
// N-port output retimer with per-port programmable delay (0..MAX_DLY); write ack/err one cycle after the strobe.
// No backpressure; a delay write is refused unless the lane is empty. CALC_RETIME_STATS_EN adds per-port response counters.
module calc_out_retimer
  import calc_retime_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RESP_W    = RESP_W_DEF,
  parameter int MAX_DLY   = 4,
  parameter int DLY_RST   = 0
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS*RESP_W-1:0]   in_resp,
  input  logic                          dly_wr,
  input  logic [idx_w(NUM_PORTS)-1:0]   dly_port,
  input  logic [dly_w(MAX_DLY)-1:0]     dly_val,
  output logic                          dly_ack,
  output logic                          dly_err,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*RESP_W-1:0]   out_resp
`ifdef CALC_RETIME_STATS_EN
  ,
  input  logic [idx_w(NUM_PORTS)-1:0]   stat_port,
  output logic [15:0]                   stat_cnt
`endif
);

  logic [NUM_PORTS-1:0] lane_empty;
  logic [NUM_PORTS-1:0] lane_ld;
  logic                 val_ok;
  logic                 port_ok;
  logic                 wr_ok;

  always_comb begin
    val_ok  = (int'(dly_val) <= MAX_DLY);
    port_ok = (int'(dly_port) < NUM_PORTS);
    wr_ok   = dly_wr && val_ok && port_ok && lane_empty[dly_port];
    lane_ld = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      lane_ld[p] = wr_ok && (int'(dly_port) == p);
    end
  end

  // Every write yields exactly one of ack/err; reset suppresses both.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      dly_ack <= 1'b0;
      dly_err <= 1'b0;
    end else begin
      dly_ack <= wr_ok;
      dly_err <= dly_wr && !wr_ok;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    calc_retime_lane #(
      .DATA_W  (DATA_W),
      .RESP_W  (RESP_W),
      .MAX_DLY (MAX_DLY),
      .DLY_RST (DLY_RST)
    ) u_lane (
      .c_clk    (c_clk),
      .reset    (reset),
      .in_data  (in_data[p*DATA_W +: DATA_W]),
      .in_resp  (in_resp[p*RESP_W +: RESP_W]),
      .dly_ld   (lane_ld[p]),
      .dly_val  (dly_val),
      .empty    (lane_empty[p]),
      .out_data (out_data[p*DATA_W +: DATA_W]),
      .out_resp (out_resp[p*RESP_W +: RESP_W])
    );
  end

`ifdef CALC_RETIME_STATS_EN
  logic [15:0] resp_cnt [NUM_PORTS];

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_cnt[p] <= '0;
      end
      stat_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if ((out_resp[p*RESP_W +: RESP_W] != RESP_W'(RESP_NONE)) && (resp_cnt[p] != 16'hFFFF)) begin
          resp_cnt[p] <= resp_cnt[p] + 16'd1;
        end
      end
      stat_cnt <= resp_cnt[stat_port];
    end
  end
`endif

endmodule

// File: tb/tb_calc_out_retimer.sv
// Scoreboard bench for calc_out_retimer: directed vectors push expected outputs, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_calc_out_retimer;
  import calc_retime_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int RW = 2;

  logic            c_clk = 1'b0;
  logic            reset;
  logic [NP*DW-1:0] in_data;
  logic [NP*RW-1:0] in_resp;
  logic            dly_wr;
  logic [1:0]      dly_port;
  logic [2:0]      dly_val;
  logic            dly_ack;
  logic            dly_err;
  logic [NP*DW-1:0] out_data;
  logic [NP*RW-1:0] out_resp;
`ifdef CALC_RETIME_STATS_EN
  logic [1:0]      stat_port;
  logic [15:0]     stat_cnt;
`endif

  always #5 c_clk = ~c_clk;

  calc_out_retimer dut (
    .c_clk    (c_clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_resp  (in_resp),
    .dly_wr   (dly_wr),
    .dly_port (dly_port),
    .dly_val  (dly_val),
    .dly_ack  (dly_ack),
    .dly_err  (dly_err),
    .out_data (out_data),
    .out_resp (out_resp)
`ifdef CALC_RETIME_STATS_EN
    ,
    .stat_port (stat_port),
    .stat_cnt  (stat_cnt)
`endif
  );

  typedef struct {
    int          cyc;
    lane_entry_t e;
  } exp_t;

  typedef struct {
    int cyc;
    bit ok;
  } wexp_t;

  exp_t  sb [NP][$];
  wexp_t wq [$];
  int    dly_m [NP];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  always @(posedge c_clk) cyc <= cyc + 1;

  // Data lanes: every cycle, every port is either the next expected response or idle with zero data.
  always @(negedge c_clk) begin : mon_data
    exp_t        ex;
    lane_entry_t got;
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        got.resp = out_resp[p*RW +: RW];
        got.data = out_data[p*DW +: DW];
        while (sb[p].size() > 0 && sb[p][0].cyc < cyc) begin
          ex = sb[p].pop_front();
          checks++; errors++;
          $display("FAIL missing_resp p%0d due cyc %0d data %0h, now cyc %0d", p, ex.cyc, ex.e.data, cyc);
        end
        checks++;
        if (got.resp != 2'(RESP_NONE)) begin
          if (sb[p].size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp p%0d cyc %0d got resp %0d data %0h want idle", p, cyc, got.resp, got.data);
          end else begin
            ex = sb[p].pop_front();
            if (ex.cyc != cyc || ex.e != got) begin
              errors++;
              $display("FAIL out_p%0d cyc %0d got resp %0d data %0h want cyc %0d resp %0d data %0h",
                       p, cyc, got.resp, got.data, ex.cyc, ex.e.resp, ex.e.data);
            end
          end
        end else if (got.data != '0) begin
          errors++;
          $display("FAIL gate_p%0d cyc %0d got data %0h want 0", p, cyc, got.data);
        end
      end
    end
  end

  always @(negedge c_clk) begin : mon_wr
    wexp_t w;
    if (mon_en) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        w = wq.pop_front();
        checks++; errors++;
        $display("FAIL missing_wr_resp due cyc %0d ok %0d, now cyc %0d", w.cyc, w.ok, cyc);
      end
      if (dly_ack || dly_err) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr_resp cyc %0d got ack %0b err %0b want none", cyc, dly_ack, dly_err);
        end else begin
          w = wq.pop_front();
          if (w.cyc != cyc || dly_ack != w.ok || dly_err == w.ok) begin
            errors++;
            $display("FAIL wr_resp cyc %0d got ack %0b err %0b want cyc %0d ack %0b err %0b",
                     cyc, dly_ack, dly_err, w.cyc, w.ok, !w.ok);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge c_clk);
    #1;
    in_resp = '0;
    in_data = '0;
    dly_wr  = 1'b0;
  endtask

  task automatic send(input int p, input logic [1:0] r, input logic [31:0] d);
    exp_t ex;
    in_resp[p*RW +: RW] = r;
    in_data[p*DW +: DW] = d;
    if (r != 2'(RESP_NONE)) begin
      ex.cyc    = cyc + dly_m[p];
      ex.e.resp = r;
      ex.e.data = d;
      sb[p].push_back(ex);
    end
  endtask

  task automatic wr(input int p, input int v, input bit ok);
    wexp_t w;
    dly_wr   = 1'b1;
    dly_port = 2'(p);
    dly_val  = 3'(v);
    w.cyc = cyc + 1;
    w.ok  = ok;
    wq.push_back(w);
    if (ok) dly_m[p] = v;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic flush_sb();
    for (int p = 0; p < NP; p++) begin
      sb[p].delete();
      dly_m[p] = 0;
    end
    wq.delete();
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    in_resp = '0; in_data = '0; dly_wr = 1'b0; dly_port = '0; dly_val = '0; reset = 1'b1;
`ifdef CALC_RETIME_STATS_EN
    stat_port = '0;
`endif
    for (int p = 0; p < NP; p++) dly_m[p] = 0;
    step(); step();
    chk("rst_out_data", out_data, '0);
    chk("rst_out_resp", out_resp, '0);
    chk("rst_ack", dly_ack, 1'b0);
    chk("rst_err", dly_err, 1'b0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Delay 0: combinational bypass.
    send(0, 2'(RESP_OK), 32'h0000_00FF);
    #1;
    chk("bypass_p0_data", out_data[31:0], 32'h0000_00FF);
    chk("bypass_p0_resp", out_resp[1:0], 2'd1);
    step();

    // Port 2 at delay 1, neighbours at delay 0 unaffected.
    wr(2, 1, 1'b1); step();
    send(2, 2'(RESP_OK), 32'h1234_5678);
    send(0, 2'(RESP_OVF), 32'h0000_AAAA);
    send(1, 2'(RESP_NONE), 32'h0000_DEAD);
    step(); step();

    // Port 1 at maximum delay: back-to-back stream.
    wr(1, 4, 1'b1); step();
    for (int i = 1; i <= 4; i++) begin
      send(1, 2'(RESP_OK), 32'(i));
      step();
    end
    repeat (6) step();

    // Reprogramming refused while busy, accepted after draining.
    wr(3, 3, 1'b1); step();
    send(3, 2'(RESP_OK), 32'h0000_0033); step();
    wr(3, 1, 1'b0); step();
    repeat (6) step();
    wr(3, 1, 1'b1); step();
    send(3, 2'(RESP_ERR), 32'h0000_0044); step(); step();

    // Out-of-range value, same-cycle arrival, back-to-back accepted writes.
    wr(0, 5, 1'b0); step();
    wr(0, 2, 1'b0); send(0, 2'(RESP_OK), 32'h0000_0055); step();
    repeat (5) step();
    wr(0, 4, 1'b1); step();
    wr(0, 2, 1'b1); step();
    wr(2, 0, 1'b1); step();
    step();

    // Reset with three responses in flight on port 1 (delay 4), plus a write colliding with reset.
    send(1, 2'(RESP_ERR), 32'h0000_00A1); step();
    send(1, 2'(RESP_OK),  32'h0000_00A2); step();
    send(1, 2'(RESP_OVF), 32'h0000_00A3); step();
    reset = 1'b1;
    dly_wr = 1'b1; dly_port = 2'd1; dly_val = 3'd1;
    flush_sb();
    step();
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_resp", out_resp, '0);
    reset = 1'b0;
    repeat (8) step();

    // All delays back to the reset value 0: same-cycle output everywhere.
    send(0, 2'(RESP_OK),  32'h0000_00B0);
    send(1, 2'(RESP_OK),  32'h0000_00B1);
    send(2, 2'(RESP_OVF), 32'h0000_00B2);
    send(3, 2'(RESP_ERR), 32'h0000_00B3);
    step(); step();

`ifdef CALC_RETIME_STATS_EN
    reset = 1'b1; flush_sb(); step(); reset = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      send(0, 2'(RESP_OK), 32'(i));
      step();
    end
    stat_port = 2'd0;
    step(); step();
    chk("stat_sat", stat_cnt, 16'hFFFF);
    reset = 1'b1; step();
    chk("stat_rst", stat_cnt, 16'h0000);
    reset = 1'b0;
    step();
`endif

    step();
    for (int p = 0; p < NP; p++) chk("sb_drained", 32'(sb[p].size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_out_retimer.md
# calc_out_retimer

Parametrised output retiming stage for the calculator family. It sits between the calculator core's per-port result outputs and the chip-level output pins. Each port's data and response pair is delayed by its own programmable number of `c_clk` cycles. This generalises the fixed one-cycle delay on port 2 to N ports, with run-time delay selection and safe reprogramming.

## Interface
- `NUM_PORTS`, default 4: number of requester ports.
- `DATA_W`, default 32: result data width per port.
- `RESP_W`, default 2: response code width per port.
- `MAX_DLY`, default 4: maximum delay in cycles (≥1).
- `DLY_RST`, default 0: delay loaded into every port on reset.

- `c_clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `in_data`, in, NUM_PORTS*DATA_W: core result data; port p occupies `[p*DATA_W +: DATA_W]`.
- `in_resp`, in, NUM_PORTS*RESP_W: core response codes (0 = none).
- `dly_wr`, in, 1: delay write strobe.
- `dly_port`, in, clog2(NUM_PORTS): target port of the write.
- `dly_val`, in, clog2(MAX_DLY+1): new delay value.
- `dly_ack`, out, 1: one-cycle pulse; write accepted.
- `dly_err`, out, 1: one-cycle pulse; write rejected.
- `out_data`, out, NUM_PORTS*DATA_W: retimed data.
- `out_resp`, out, NUM_PORTS*RESP_W: retimed responses.

## Operation
- Each port has a MAX_DLY-stage shift register. It shifts every cycle, regardless of content.
- Stage 0 captures `{in_resp, in_data & {DATA_W{in_resp!=0}}}`. Data is therefore zero whenever the response is zero.
- Output tap for port p is selected by `dly[p]`:
  - `dly[p]==0`: combinational bypass from the gated input.
  - Otherwise: stage `dly[p]-1`.
- Delay write is sampled when `dly_wr=1`. The write is accepted only if all of these hold:
  - `dly_val ≤ MAX_DLY`;
  - `dly_port < NUM_PORTS`;
  - the target lane is empty, meaning no stage holds a nonzero response and `in_resp[p]==0` this cycle.
- Accepted write: `dly[p]` updates at the edge, and `dly_ack` pulses on the next cycle.
- Rejected write: no change, and `dly_err` pulses on the next cycle.
- Each write produces exactly one of `dly_ack` or `dly_err`.
- Back-to-back writes are legal, one per cycle.
- Responses are never dropped, duplicated or reordered within a port.
- Ports are fully independent.

## Timing
- On reset, all of the following are zero the next cycle:
  - all stages;
  - `out_data`;
  - `out_resp` (out_data/out_resp are 0 when `dly=0` only if `in_resp` is 0);
  - `dly_ack`;
  - `dly_err`.
- Also on reset, every `dly[p]` is set to `DLY_RST`.
- Reset mid-flight discards all in-flight responses silently.
- Latency: an input seen at edge t appears on the output after the edge at t+d-1, i.e. d cycles later. For d=0 it appears the same cycle.
- A delay change takes effect for inputs sampled after the accepting edge. Since the lane is empty, the change never exposes stale entries.
- `dly_wr` together with `reset`: reset wins, and no ack or err is produced.

## Configuration
- `CALC_RETIME_STATS_EN` defined:
  - Adds a 16-bit saturating count of nonzero `out_resp` cycles per port.
  - Adds input `stat_port` (clog2(NUM_PORTS)) and output `stat_cnt` (16), a registered read with 1-cycle latency.
  - Counts clear on reset.
  - A count holds at 0xFFFF once saturated.
- `CALC_RETIME_STATS_EN` undefined: those ports and counters are absent, and nothing else differs.

## Structure
- Package `calc_retime_pkg` holds:
  - `DATA_W` and `RESP_W` defaults;
  - response code constants: `RESP_NONE=0`, `RESP_OK=1`, `RESP_OVF=2`, `RESP_ERR=3`;
  - the `lane_entry_t` struct (`resp`, `data`);
  - the delay-index width function.
- Sub-module `calc_retime_lane` contains one port's shift register, tap mux, empty flag and delay register. The top instantiates NUM_PORTS lanes and the write decode.

## Test plan
- Reset, then port 0 at delay 0 with `in_resp=1`, `in_data=0x0000_00FF` → out appears the same cycle with identical values.
- Write port 2 with `dly_val=1`, then drive `resp=1`, `data=0x1234_5678` → out_data2 appears exactly 1 cycle later; other ports are unaffected.
- Port 1 at delay 4; drive 4 consecutive responses with data 1,2,3,4 → outputs appear in order on cycles t+4..t+7 with no gaps.
- With port 3 at delay 3 and one response in flight, write `dly_val=1` → `dly_err` pulses and the response exits at the original delay. The same write after the lane drains → `dly_ack` pulses.
- Write `dly_val=5` with MAX_DLY=4 → `dly_err` pulses. Assert reset with 3 responses in flight → all outputs are 0 the next cycle, none emerge later, and all delays equal DLY_RST.
- With `CALC_RETIME_STATS_EN`: 70000 responses on port 0 → `stat_cnt=0xFFFF`. Reset → `stat_cnt=0`.
